// File: rtl/calc_sequencer.sv
`default_nettype none
// calc_sequencer: keypad-driven calculator sequencer. Builds signed fixed-point operands
// from key codes and issues one operation at a time to an external start/done ALU.
module calc_sequencer #(
  parameter int WIDTH          = 64,
  parameter int FRAC_DIGITS    = 2,
  parameter int MAX_INT_DIGITS = 9
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [3:0]       button_i,
  input  logic             is_pressed_i,
  output logic [WIDTH-1:0] operand_a_o,
  output logic [WIDTH-1:0] operand_b_o,
  output logic [1:0]       alu_op_o,
  output logic             alu_start_o,
  input  logic             alu_done_i,
  input  logic [WIDTH-1:0] alu_result_i,
  input  logic             alu_error_i,
  output logic [WIDTH-1:0] display_value_o,
  output logic             display_error_o,
  output logic [2:0]       state_o
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_OPA    = 3'd1;
  localparam logic [2:0] S_OP     = 3'd2;
  localparam logic [2:0] S_OPB    = 3'd3;
  localparam logic [2:0] S_EXEC   = 3'd4;
  localparam logic [2:0] S_RESULT = 3'd5;
  localparam logic [2:0] S_ERROR  = 3'd6;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_DIV = 2'd3;

  function automatic logic [127:0] pow10_wide(input int n);
    logic [127:0] p;
    p = 128'd1;
    for (int i = 0; i < n; i++) p = p * 128'd10;
    return p;
  endfunction

  localparam logic [WIDTH-1:0] TEN   = WIDTH'(10);
  localparam logic [WIDTH-1:0] SCALE = WIDTH'(pow10_wide(FRAC_DIGITS));

  // Largest entry is 10^(MAX_INT_DIGITS+FRAC_DIGITS)-1 and must stay positive as a signed value.
  localparam logic [127:0] ENTRY_LIMIT = pow10_wide(MAX_INT_DIGITS + FRAC_DIGITS);
  localparam logic [127:0] SIGNED_MAX  = 128'd1 << (WIDTH - 1);

  generate
    if (ENTRY_LIMIT > SIGNED_MAX) begin : g_width_check
      $error("calc_sequencer: WIDTH too small for MAX_INT_DIGITS + FRAC_DIGITS");
    end
  endgenerate

  function automatic logic [WIDTH-1:0] frac_weight(input logic [7:0] k);
    logic [WIDTH-1:0] w;
    w = {{(WIDTH-1){1'b0}}, 1'b1};
    for (int i = 0; i < FRAC_DIGITS; i++)
      if (i + 1 + int'(k) < FRAC_DIGITS) w = w * TEN;
    return w;
  endfunction

  logic [2:0]       state_q, state_d;
  logic [WIDTH-1:0] operand_a_q, operand_a_d;
  logic [WIDTH-1:0] operand_b_q, operand_b_d;
  logic [1:0]       alu_op_q, alu_op_d;
  logic [1:0]       chain_op_q, chain_op_d;
  logic             chain_q, chain_d;
  logic             issue_q, issue_d;
  logic             shift_q, shift_d;
  logic             pressed_q;
  logic [WIDTH-1:0] mag_q, mag_d;
  logic             neg_q, neg_d;
  logic             dec_q, dec_d;
  logic [7:0]       int_cnt_q, int_cnt_d;
  logic [7:0]       frac_cnt_q, frac_cnt_d;

  logic             key_evt;
  logic             is_digit, is_op, is_equal, is_clear, is_toggle, is_neg, is_dec;
  logic [1:0]       key_op;

  assign key_evt = is_pressed_i & ~pressed_q;

  always_comb begin
    is_digit  = 1'b0;
    is_op     = 1'b0;
    is_equal  = 1'b0;
    is_clear  = 1'b0;
    is_toggle = 1'b0;
    is_neg    = 1'b0;
    is_dec    = 1'b0;
    key_op    = OP_ADD;
    if (key_evt) begin
      case (button_i)
        4'hA: begin
          is_op  = 1'b1;
          key_op = shift_q ? OP_DIV : OP_ADD;
        end
        4'hB: begin
          if (shift_q) is_dec = 1'b1;
          else begin
            is_op  = 1'b1;
            key_op = OP_SUB;
          end
        end
        4'hC: begin
          if (shift_q) is_neg = 1'b1;
          else begin
            is_op  = 1'b1;
            key_op = OP_MUL;
          end
        end
        4'hD:    is_toggle = 1'b1;
        4'hE:    is_equal  = 1'b1;
        4'hF:    is_clear  = 1'b1;
        default: is_digit  = 1'b1;
      endcase
    end
  end

  // Entry editing is applied either to the live operand or to a fresh empty one.
  logic             fresh;
  logic [WIDTH-1:0] base_mag, nxt_mag, digit_ext, entry_val;
  logic             base_neg, base_dec, nxt_neg, nxt_dec;
  logic [7:0]       base_int, base_frac, nxt_int, nxt_frac;

  assign fresh     = (state_q == S_IDLE) || (state_q == S_OP) || (state_q == S_RESULT);
  assign digit_ext = {{(WIDTH-4){1'b0}}, button_i};
  assign entry_val = neg_q ? -mag_q : mag_q;

  always_comb begin
    base_mag  = fresh ? '0    : mag_q;
    base_neg  = fresh ? 1'b0  : neg_q;
    base_dec  = fresh ? 1'b0  : dec_q;
    base_int  = fresh ? 8'd0  : int_cnt_q;
    base_frac = fresh ? 8'd0  : frac_cnt_q;
    nxt_mag   = base_mag;
    nxt_neg   = base_neg;
    nxt_dec   = base_dec;
    nxt_int   = base_int;
    nxt_frac  = base_frac;
    if (is_digit) begin
      if (!base_dec) begin
        if (base_int < 8'(MAX_INT_DIGITS)) begin
          nxt_mag = base_mag * TEN + digit_ext * SCALE;
          nxt_int = base_int + 8'd1;
        end
      end else if (base_frac < 8'(FRAC_DIGITS)) begin
        nxt_mag  = base_mag + digit_ext * frac_weight(base_frac);
        nxt_frac = base_frac + 8'd1;
      end
    end else if (is_neg) begin
      nxt_neg = ~base_neg;
    end else if (is_dec) begin
      nxt_dec = 1'b1;
    end
  end

  logic entry_key, load_entry, div_zero;
  assign entry_key = is_digit | is_neg | is_dec;
  assign div_zero  = (alu_op_q == OP_DIV) && (operand_b_q == '0);

  always_comb begin
    state_d     = state_q;
    operand_a_d = operand_a_q;
    operand_b_d = operand_b_q;
    alu_op_d    = alu_op_q;
    chain_d     = chain_q;
    chain_op_d  = chain_op_q;
    issue_d     = 1'b0;
    shift_d     = shift_q;
    mag_d       = mag_q;
    neg_d       = neg_q;
    dec_d       = dec_q;
    int_cnt_d   = int_cnt_q;
    frac_cnt_d  = frac_cnt_q;
    load_entry  = 1'b0;

    if (is_toggle)    shift_d = ~shift_q;
    else if (key_evt) shift_d = 1'b0;

    if (is_clear) begin
      state_d     = S_IDLE;
      operand_a_d = '0;
      operand_b_d = '0;
      alu_op_d    = OP_ADD;
      chain_d     = 1'b0;
      chain_op_d  = OP_ADD;
      mag_d       = '0;
      neg_d       = 1'b0;
      dec_d       = 1'b0;
      int_cnt_d   = 8'd0;
      frac_cnt_d  = 8'd0;
    end else begin
      case (state_q)
        S_IDLE: if (entry_key) begin
          load_entry = 1'b1;
          state_d    = S_OPA;
        end
        S_OPA: begin
          if (is_op) begin
            operand_a_d = entry_val;
            alu_op_d    = key_op;
            state_d     = S_OP;
          end else if (entry_key) load_entry = 1'b1;
        end
        S_OP: begin
          if (is_op) alu_op_d = key_op;
          else if (entry_key) begin
            load_entry = 1'b1;
            state_d    = S_OPB;
          end
        end
        S_OPB: begin
          if (is_equal || is_op) begin
            operand_b_d = entry_val;
            chain_d     = is_op;
            chain_op_d  = key_op;
            issue_d     = 1'b1;
            state_d     = S_EXEC;
          end else if (entry_key) load_entry = 1'b1;
        end
        S_EXEC: begin
          // The request cycle never accepts a done, so a result always follows the pulse.
          if (issue_q) begin
            if (div_zero) state_d = S_ERROR;
          end else if (alu_done_i) begin
            if (alu_error_i) state_d = S_ERROR;
            else begin
              operand_a_d = alu_result_i;
              if (chain_q) begin
                alu_op_d = chain_op_q;
                state_d  = S_OP;
              end else begin
                state_d  = S_RESULT;
              end
            end
          end
        end
        S_RESULT: begin
          if (is_op) begin
            alu_op_d = key_op;
            state_d  = S_OP;
          end else if (is_digit) begin
            load_entry = 1'b1;
            state_d    = S_OPA;
          end
        end
        S_ERROR: ;
        default: state_d = S_IDLE;
      endcase
    end

    if (load_entry) begin
      mag_d      = nxt_mag;
      neg_d      = nxt_neg;
      dec_d      = nxt_dec;
      int_cnt_d  = nxt_int;
      frac_cnt_d = nxt_frac;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      operand_a_q <= '0;
      operand_b_q <= '0;
      alu_op_q    <= OP_ADD;
      chain_q     <= 1'b0;
      chain_op_q  <= OP_ADD;
      issue_q     <= 1'b0;
      shift_q     <= 1'b0;
      pressed_q   <= 1'b0;
      mag_q       <= '0;
      neg_q       <= 1'b0;
      dec_q       <= 1'b0;
      int_cnt_q   <= 8'd0;
      frac_cnt_q  <= 8'd0;
    end else begin
      state_q     <= state_d;
      operand_a_q <= operand_a_d;
      operand_b_q <= operand_b_d;
      alu_op_q    <= alu_op_d;
      chain_q     <= chain_d;
      chain_op_q  <= chain_op_d;
      issue_q     <= issue_d;
      shift_q     <= shift_d;
      pressed_q   <= is_pressed_i;
      mag_q       <= mag_d;
      neg_q       <= neg_d;
      dec_q       <= dec_d;
      int_cnt_q   <= int_cnt_d;
      frac_cnt_q  <= frac_cnt_d;
    end
  end

  always_comb begin
    case (state_q)
      S_OPA, S_OPB:             display_value_o = entry_val;
      S_OP, S_EXEC, S_RESULT:   display_value_o = operand_a_q;
      default:                  display_value_o = '0;
    endcase
  end

  assign operand_a_o     = operand_a_q;
  assign operand_b_o     = operand_b_q;
  assign alu_op_o        = alu_op_q;
  assign alu_start_o     = (state_q == S_EXEC) && issue_q && !div_zero;
  assign display_error_o = (state_q == S_ERROR);
  assign state_o         = state_q;

endmodule
`default_nettype wire
